// File: rtl/uart_json_motor_tx.sv
// uart_json_motor_tx: turns a signed left/right wheel speed pair into the ASCII
// frame {"T":<CMD_T>,"L":<num>,"R":<num>} and streams it byte by byte to a
// uart_tx over a valid/ready handshake. Magnitudes are converted to BCD by a
// serial double-dabble (one bit per cycle, both channels in parallel).
// Optional feature macro: UART_JSON_LF_EN appends a line feed after '}'.
module uart_json_motor_tx #(
    parameter int SPEED_W     = 16,
    parameter int NDIG        = 5,
    parameter int FRAC_DIGITS = 2,
    parameter int CMD_T       = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic signed [SPEED_W-1:0] speed_l,
    input  logic signed [SPEED_W-1:0] speed_r,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic                      busy,
    output logic                      frame_done
);

    // Frame layout as a fixed list of slots; suppressed slots (sign of a
    // positive value, leading integer zeros) are skipped when advancing.
    localparam int NI     = NDIG - FRAC_DIGITS;
    localparam int DOT    = (FRAC_DIGITS > 0) ? 1 : 0;
    localparam int NUMLEN = 1 + NI + DOT + FRAC_DIGITS;
    localparam int LB     = 11;
    localparam int MB     = LB + NUMLEN;
    localparam int RB     = MB + 5;
    localparam int CB     = RB + NUMLEN;
`ifdef UART_JSON_LF_EN
    localparam int NSLOT  = CB + 2;
`else
    localparam int NSLOT  = CB + 1;
`endif
    localparam int LAST   = NSLOT - 1;
    localparam int IW     = $clog2(NSLOT + 1);
    localparam int CW     = $clog2(SPEED_W + 1);
    localparam int BW     = 4 * NDIG;
    localparam logic [63:0] SAT_VAL = 64'(10 ** NDIG - 1);

    typedef enum logic [1:0] {IDLE, CONV, SEND} state_t;

    state_t                 state, state_next;
    logic                   last_hs;
    logic [CW-1:0]          cnt;
    logic [IW-1:0]          idx, nxt;
    logic                   found;
    logic                   neg_l, neg_r;
    logic [SPEED_W-1:0]     bin_l, bin_r;
    logic [BW-1:0]          bcd_l, bcd_r;
    logic [7:0]             slot_char [NSLOT];
    logic [NSLOT-1:0]       emit_mask;

    // |s| as unsigned (the most negative value maps cleanly), clamped to 10^NDIG-1
    function automatic logic [SPEED_W-1:0] abs_sat(input logic signed [SPEED_W-1:0] s);
        logic [SPEED_W-1:0] m;
        m = s[SPEED_W-1] ? SPEED_W'(-s) : SPEED_W'(s);
        if (64'(m) > SAT_VAL)
            abs_sat = SPEED_W'(SAT_VAL);
        else
            abs_sat = m;
    endfunction

    // double-dabble correction: add 3 to every BCD digit >= 5 before the shift
    function automatic logic [BW-1:0] dd_adj(input logic [BW-1:0] b);
        dd_adj = b;
        for (int d = 0; d < NDIG; d++)
            if (b[4*d +: 4] >= 4'd5)
                dd_adj[4*d +: 4] = b[4*d +: 4] + 4'd3;
    endfunction

    function automatic logic [7:0] pre_char(input int k);
        case (k)
            0:       pre_char = 8'h7B;
            1, 3, 7, 9: pre_char = 8'h22;
            2:       pre_char = 8'h54;
            4, 10:   pre_char = 8'h3A;
            5:       pre_char = 8'(48 + CMD_T);
            6:       pre_char = 8'h2C;
            8:       pre_char = 8'h4C;
            default: pre_char = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] mid_char(input int k);
        case (k)
            0:       mid_char = 8'h2C;
            1, 3:    mid_char = 8'h22;
            2:       mid_char = 8'h52;
            4:       mid_char = 8'h3A;
            default: mid_char = 8'h00;
        endcase
    endfunction

    // character at position j of a rendered number: sign, integer digits, '.', fraction
    function automatic logic [7:0] num_char(input logic [BW-1:0] b, input int j);
        int d;
        d = 0;
        num_char = 8'h2D;
        if (j >= 1 && j <= NI) begin
            d = NDIG - j;
            num_char = {4'h3, b[4*d +: 4]};
        end else if (DOT != 0 && j == NI + 1) begin
            num_char = 8'h2E;
        end else if (j > NI) begin
            d = NDIG + DOT - j;
            num_char = {4'h3, b[4*d +: 4]};
        end
    endfunction

    // whether position j is emitted: sign only if negative, leading zeros
    // suppressed but the last integer digit always kept
    function automatic logic num_emit(input logic neg, input logic [BW-1:0] b, input int j);
        num_emit = 1'b1;
        if (j == 0) begin
            num_emit = neg;
        end else if (j >= 1 && j < NI) begin
            num_emit = 1'b0;
            for (int k = 1; k <= NI; k++)
                if (k <= j && b[4*(NDIG-k) +: 4] != 4'd0)
                    num_emit = 1'b1;
        end
    endfunction

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // FSM next state and handshake/status outputs
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        busy       = 1'b1;
        last_hs    = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid)
                    state_next = CONV;
            end
            CONV: begin
                if (cnt == CW'(SPEED_W - 1))
                    state_next = SEND;
            end
            SEND: begin
                if (tx_valid && tx_ready && idx == IW'(LAST)) begin
                    last_hs    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // render every slot of the frame and mark which ones are emitted
    always_comb begin
        slot_char = '{default: 8'h00};
        emit_mask = '0;
        for (int k = 0; k < 11; k++) begin
            slot_char[k] = pre_char(k);
            emit_mask[k] = 1'b1;
        end
        for (int j = 0; j < NUMLEN; j++) begin
            slot_char[LB+j] = num_char(bcd_l, j);
            emit_mask[LB+j] = num_emit(neg_l, bcd_l, j);
            slot_char[RB+j] = num_char(bcd_r, j);
            emit_mask[RB+j] = num_emit(neg_r, bcd_r, j);
        end
        for (int k = 0; k < 5; k++) begin
            slot_char[MB+k] = mid_char(k);
            emit_mask[MB+k] = 1'b1;
        end
        slot_char[CB] = 8'h7D;
        emit_mask[CB] = 1'b1;
`ifdef UART_JSON_LF_EN
        slot_char[CB+1] = 8'h0A;
        emit_mask[CB+1] = 1'b1;
`endif
    end

    // next emitted slot; at most NI slots in a row can be suppressed
    always_comb begin
        nxt   = idx;
        found = 1'b0;
        for (int k = 1; k <= NI + 1; k++) begin
            if (!found && (int'(idx) + k) < NSLOT && emit_mask[int'(idx) + k]) begin
                nxt   = IW'(int'(idx) + k);
                found = 1'b1;
            end
        end
    end

    // control: conversion counter, byte pointer, registered tx outputs, done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            tx_valid   <= 1'b0;
            tx_data    <= 8'h00;
            frame_done <= 1'b0;
        end else begin
            frame_done <= last_hs;
            case (state)
                IDLE: cnt <= '0;
                CONV: cnt <= cnt + 1'b1;
                SEND: begin
                    if (!tx_valid) begin
                        tx_valid <= 1'b1;
                        tx_data  <= slot_char[0];
                        idx      <= '0;
                    end else if (tx_ready) begin
                        if (last_hs) begin
                            tx_valid <= 1'b0;
                        end else begin
                            idx     <= nxt;
                            tx_data <= slot_char[nxt];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // data: latch sign/magnitude on accept, then one double-dabble shift per CONV cycle
    always_ff @(posedge clk) begin
        if (state == IDLE && cmd_valid) begin
            neg_l <= speed_l[SPEED_W-1];
            neg_r <= speed_r[SPEED_W-1];
            bin_l <= abs_sat(speed_l);
            bin_r <= abs_sat(speed_r);
            bcd_l <= '0;
            bcd_r <= '0;
        end else if (state == CONV) begin
            bcd_l <= BW'({dd_adj(bcd_l), bin_l[SPEED_W-1]});
            bcd_r <= BW'({dd_adj(bcd_r), bin_r[SPEED_W-1]});
            bin_l <= bin_l << 1;
            bin_r <= bin_r << 1;
        end
    end

endmodule

// File: tb/tb_uart_json_motor_tx.sv
// Directed bench for uart_json_motor_tx: default-width instance plus a
// SPEED_W=20 instance for the saturation case.
module tb_uart_json_motor_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, tx_ready;
    logic cv0, cr0, tv0, busy0, fd0;
    logic [7:0] td0;
    logic signed [15:0] sl0, sr0;
    logic cv1, cr1, tv1, busy1, fd1;
    logic [7:0] td1;
    logic signed [19:0] sl1, sr1;

    uart_json_motor_tx dut0 (
        .clk(clk), .rst(rst), .cmd_valid(cv0), .cmd_ready(cr0),
        .speed_l(sl0), .speed_r(sr0), .tx_data(td0), .tx_valid(tv0),
        .tx_ready(tx_ready), .busy(busy0), .frame_done(fd0)
    );

    uart_json_motor_tx #(.SPEED_W(20)) dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cv1), .cmd_ready(cr1),
        .speed_l(sl1), .speed_r(sr1), .tx_data(td1), .tx_valid(tv1),
        .tx_ready(tx_ready), .busy(busy1), .frame_done(fd1)
    );

    int sel;
    logic o_valid, o_ready, o_busy, o_fd;
    logic [7:0] o_data;
    assign o_valid = (sel == 1) ? tv1   : tv0;
    assign o_ready = (sel == 1) ? cr1   : cr0;
    assign o_busy  = (sel == 1) ? busy1 : busy0;
    assign o_fd    = (sel == 1) ? fd1   : fd0;
    assign o_data  = (sel == 1) ? td1   : td0;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic string frame(input string l, input string r);
        string s;
        s = {"{\"T\":1,\"L\":", l, ",\"R\":", r, "}"};
`ifdef UART_JSON_LF_EN
        s = {s, "\n"};
`endif
        return s;
    endfunction

    // present a command, wait (bounded) for cmd_ready, consume the accept edge
    task automatic send(input int s, input int l, input int r);
        @(negedge clk);
        if (s == 1) begin cv1 = 1'b1; sl1 = 20'(l); sr1 = 20'(r); end
        else        begin cv0 = 1'b1; sl0 = 16'(l); sr0 = 16'(r); end
        for (int i = 0; i < 50 && !o_ready; i++) @(negedge clk);
        chk("accept_ready", o_ready, 1);
        @(posedge clk);
        #1;
        cv0 = 1'b0; cv1 = 1'b0;
        sl0 = 16'sh5a5a; sr0 = -16'sd4321;
        sl1 = 20'sh5a5a5; sr1 = -20'sd4321;
    endtask

    // collect one frame (called right after the accept edge)
    task automatic capture(input string tag, input string exp, input bit lat_chk,
                           input int stall_at, input int abort_at);
        byte got[$];
        int cyc, last_hs, lat;
        bit stalled, done;
        cyc = 0; last_hs = -10; lat = -1; stalled = 0; done = 0;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (lat_chk && cyc == 1) begin
                chk({tag, ".busy_after_accept"}, o_busy, 1);
                chk({tag, ".ready_after_accept"}, o_ready, 0);
            end
            if (lat < 0 && o_valid) lat = cyc - 1;
            if (abort_at >= 0 && got.size() == abort_at && o_valid) begin
                rst = 1'b1;
                @(negedge clk);
                chk({tag, ".rst_tx_valid"}, o_valid, 0);
                chk({tag, ".rst_cmd_ready"}, o_ready, 1);
                chk({tag, ".rst_busy"}, o_busy, 0);
                chk({tag, ".rst_tx_data"}, o_data, 0);
                chk({tag, ".rst_frame_done"}, o_fd, 0);
                rst = 1'b0;
                return;
            end
            if (stall_at >= 0 && !stalled && got.size() == stall_at && o_valid) begin
                stalled = 1;
                tx_ready = 1'b0;
                cv0 = 1'b1; sl0 = 16'sd7; sr0 = -16'sd5;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    cyc++;
                    chk({tag, ".stall_data"}, o_data, 64'(exp[stall_at]));
                    chk({tag, ".stall_valid"}, o_valid, 1);
                    chk({tag, ".busy_cmd_ready"}, cr0, 0);
                end
                tx_ready = 1'b1;
            end
            if (o_fd) begin
                chk({tag, ".done_timing"}, cyc, last_hs + 1);
                chk({tag, ".done_tx_valid"}, o_valid, 0);
                chk({tag, ".done_cmd_ready"}, o_ready, 1);
                chk({tag, ".done_busy"}, o_busy, 0);
                done = 1;
            end else if (o_valid && tx_ready) begin
                got.push_back(byte'(o_data));
                last_hs = cyc;
            end
        end
        chk({tag, ".frame_done_seen"}, done, 1);
        if (lat_chk) chk({tag, ".latency"}, lat, (sel == 1) ? 21 : 17);
        chk({tag, ".length"}, got.size(), exp.len());
        for (int i = 0; i < exp.len(); i++)
            chk($sformatf("%s.byte%0d", tag, i), (i < got.size()) ? 64'(got[i]) : 64'hff, 64'(exp[i]));
    endtask

    initial begin
        rst = 1'b1; tx_ready = 1'b1; sel = 0;
        cv0 = 1'b0; sl0 = '0; sr0 = '0;
        cv1 = 1'b0; sl1 = '0; sr1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.cmd_ready", cr0, 1);
        chk("reset.tx_valid", tv0, 0);
        chk("reset.tx_data", td0, 0);
        chk("reset.busy", busy0, 0);
        chk("reset.frame_done", fd0, 0);
        rst = 1'b0;

        send(0, 50, 50);
        capture("f50_50", frame("0.50", "0.50"), 1, -1, -1);
        send(0, -100, 250);
        capture("fneg100", frame("-1.00", "2.50"), 1, -1, -1);
        send(0, -32768, 0);
        capture("fmin", frame("-327.68", "0.00"), 1, -1, -1);
        send(0, 32767, -1);
        capture("fmax", frame("327.67", "-0.01"), 0, -1, -1);

        // stall at byte 5 while a second command waits; it is taken when frame_done is high
        send(0, 1234, -9);
        capture("fstall", frame("12.34", "-0.09"), 0, 5, -1);
        chk("held_cmd_ready_at_done", cr0, 1);
        @(posedge clk);
        #1;
        cv0 = 1'b0;
        capture("fheld", frame("0.07", "-0.05"), 1, -1, -1);

        // reset in the middle of a frame, then a fresh complete frame
        send(0, 4321, 4321);
        capture("fabort", frame("43.21", "43.21"), 0, -1, 12);
        send(0, 300, -2050);
        capture("fafter", frame("3.00", "-20.50"), 1, -1, -1);

        // saturation on the 20-bit instance
        sel = 1;
        send(1, 200000, -3);
        capture("fsat", frame("999.99", "-0.03"), 1, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
